// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set controller: FSM encoding, button indices, defaults.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

  localparam int unsigned NUM_BTN  = 4;
  localparam int unsigned MIN_INC  = 0;
  localparam int unsigned MIN_DEC  = 1;
  localparam int unsigned HOUR_INC = 2;
  localparam int unsigned HOUR_DEC = 3;

  localparam int unsigned DB_CNT_DEF  = 50000;
  localparam int unsigned RPT_DLY_DEF = 25000000;
  localparam int unsigned RPT_PER_DEF = 5000000;

  // Index of the highest set bit; callers only use it on one-hot vectors.
  function automatic logic [1:0] btn_index(input logic [NUM_BTN-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw push button.
module btn_debounce
  import time_set_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

  // Count consecutive disagreeing cycles; any agreement clears the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync_q[1];
      else                   cnt_d   = cnt_q + CW'(1);
    end
  end

  // Debounced level and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set button controller: debounces four buttons and emits single-cycle adjust
// pulses. Auto-repeat on a held button is built only with TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned DB_CNT  = DB_CNT_DEF,
  parameter int unsigned RPT_DLY = RPT_DLY_DEF,
  parameter int unsigned RPT_PER = RPT_PER_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_en,
  input  logic btn_min_inc,
  input  logic btn_min_dec,
  input  logic btn_hour_inc,
  input  logic btn_hour_dec,
  output logic min_inc,
  output logic min_dec,
  output logic hour_inc,
  output logic hour_dec,
  output logic busy
);

  logic [NUM_BTN-1:0] raw, db;
  logic [NUM_BTN-1:0] latched;
  logic               abort;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               busy_q;

  assign raw = {btn_hour_dec, btn_hour_inc, btn_min_dec, btn_min_inc};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk    (clk),
      .rst_n  (reset_n),
      .btn_i  (raw[i]),
      .level_o(db[i])
    );
  end

  assign latched = 4'b0001 << idx_q;
  // A second button or leaving set mode locks out further pulses.
  assign abort   = !set_en || (|(db & ~latched));

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int unsigned RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;

  // Repeat timer; cleared on every pulse and state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rcnt_q <= '0;
    else          rcnt_q <= rcnt_d;
  end
`endif

  // Next state, latched index and pulse selection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pulse_d = '0;
`ifdef TIME_SET_AUTO_REPEAT_EN
    rcnt_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (db != '0) begin
          if (set_en && $onehot(db)) begin
            pulse_d = db;
            idx_d   = btn_index(db);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOCK;
          end
        end
      end
      ST_HOLD: begin
        if (abort)              state_d = ST_LOCK;
        else if (!db[idx_q])    state_d = ST_IDLE;
`ifdef TIME_SET_AUTO_REPEAT_EN
        else if (rcnt_q == DLY_LAST) begin
          pulse_d = latched;
          state_d = ST_REPEAT;
        end else                rcnt_d  = rcnt_q + RW'(1);
`endif
      end
`ifdef TIME_SET_AUTO_REPEAT_EN
      ST_REPEAT: begin
        if (abort)                   state_d = ST_LOCK;
        else if (!db[idx_q])         state_d = ST_IDLE;
        else if (rcnt_q == PER_LAST) pulse_d = latched;
        else                         rcnt_d  = rcnt_q + RW'(1);
      end
`endif
      ST_LOCK: begin
        if (db == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign min_inc  = pulse_q[MIN_INC];
  assign min_dec  = pulse_q[MIN_DEC];
  assign hour_inc = pulse_q[HOUR_INC];
  assign hour_dec = pulse_q[HOUR_DEC];
  assign busy     = busy_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with short debounce/repeat parameters and a cycle-level reference model.
module tb_time_set_ctrl;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int HMAX = 8192;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       set_en = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       min_inc, min_dec, hour_inc, hour_dec, busy;
  logic [3:0] obs_p;

  time_set_ctrl #(.DB_CNT(DB), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .set_en      (set_en),
    .btn_min_inc (btn[0]),
    .btn_min_dec (btn[1]),
    .btn_hour_inc(btn[2]),
    .btn_hour_dec(btn[3]),
    .min_inc     (min_inc),
    .min_dec     (min_dec),
    .hour_inc    (hour_inc),
    .hour_dec    (hour_dec),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  assign obs_p = {hour_dec, hour_inc, min_dec, min_inc};

  int checks = 0;
  int failures = 0;

  // Reference model: raw input history plus a behavioural view of the controller.
  bit [3:0] hist [0:HMAX-1];
  int       cyc = 0;
  int       rel = 1;        // first edge whose input the synchronizer captures
  bit [3:0] db_m = 4'b0000;
  int       mode = 0;       // 0 idle, 1 owned by one button, 2 locked
  int       owner = 0;
  int       last_p = 0;
  int       npulse = 0;
  bit [3:0] exp_p = 4'b0000;
  bit       exp_busy = 1'b0;

  function automatic bit [3:0] in_at(input int k);
    if (k < rel || k < 1 || k >= HMAX) return 4'b0000;
    return hist[k];
  endfunction

  task automatic model_clear();
    db_m = 4'b0000; mode = 0; exp_p = 4'b0000; exp_busy = 1'b0; npulse = 0;
  endtask

  // Behaviour at edge n using debounced levels from before the edge.
  task automatic model_edge(input int n, input bit en);
    bit [3:0] others;
    bit [3:0] v;
    bit       flip;
    exp_p = 4'b0000;
    case (mode)
      0: if (db_m != 4'b0000) begin
           if (en && $countones(db_m) == 1) begin
             for (int b = 0; b < 4; b++) if (db_m[b]) owner = b;
             exp_p = db_m; last_p = n; npulse = 1; mode = 1;
           end else mode = 2;
         end
      1: begin
           others = db_m & ~(4'b0001 << owner);
           if (!en || others != 4'b0000) mode = 2;
           else if (!db_m[owner]) mode = 0;
           else if (AUTO && (n - last_p) == ((npulse == 1) ? DLY : PER)) begin
             exp_p[owner] = 1'b1; last_p = n; npulse++;
           end
         end
      default: if (db_m == 4'b0000) mode = 0;
    endcase
    exp_busy = (mode != 0);
    // Debounced level follows once the synchronized input disagreed for DB whole cycles.
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int k = n - DB - 1; k <= n - 2; k++) begin
        v = in_at(k);
        if (v[b] == db_m[b]) flip = 1'b0;
      end
      if (flip) db_m[b] = ~db_m[b];
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, land 1ns after the edge.
  task automatic tick(input bit [3:0] b, input bit en);
    btn = b; set_en = en;
    @(posedge clk);
    cyc++;
    if (cyc < HMAX) hist[cyc] = b;
    if (!reset_n) begin
      model_clear();
      rel = cyc + 1;
    end else begin
      model_edge(cyc, en);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({obs_p, busy} !== 5'b00000) begin
      failures++; $display("FAIL reset_async got=%b exp=00000", {obs_p, busy});
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'b1111, 1'b1);
      checks++;
      if ({obs_p, busy} !== 5'b00000) begin
        failures++; $display("FAIL reset_hold i=%0d got=%b exp=00000", i, {obs_p, busy});
      end
    end
    tick(4'b0000, 1'b1);
    reset_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int first = -1;
    int cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick((i < 10) ? 4'b0001 : 4'b0000, 1'b1);
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL clean_press i=%0d got=%b exp=%b", i, {obs_p, busy}, {exp_p, exp_busy});
      end
      if (obs_p != 4'b0000) begin
        cnt++;
        if (first < 0) first = i + 1;
      end
    end
    checks++;
    if (first != 2 + DB + 1 || cnt != 1) begin
      failures++; $display("FAIL clean_latency first=%0d cnt=%0d exp first=%0d cnt=1", first, cnt, 2 + DB + 1);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    bit [3:0] b;
    for (int i = 0; i < 45; i++) begin
      if (i < 12)      b = ((i / 2) % 2 == 0) ? 4'b1000 : 4'b0000;
      else if (i < 30) b = 4'b1000;
      else             b = 4'b0000;
      tick(b, 1'b1);
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL bounce i=%0d got=%b exp=%b", i, {obs_p, busy}, {exp_p, exp_busy});
      end
      if (obs_p != 4'b0000 && first < 0) first = i - 12 + 1;
    end
    checks++;
    if (first != 7) begin
      failures++; $display("FAIL bounce_latency got=%0d exp=7", first);
    end
  endtask

  task automatic test_repeat();
    int t[$];
    for (int i = 0; i < 80; i++) begin
      tick((i < 60) ? 4'b0010 : 4'b0000, 1'b1);
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL repeat i=%0d got=%b exp=%b", i, {obs_p, busy}, {exp_p, exp_busy});
      end
      if (min_dec === 1'b1) t.push_back(i + 1);
    end
    checks++;
    if (AUTO) begin
      if (t.size() < 3 || t[0] != 7 || t[1] - t[0] != DLY || t[2] - t[1] != PER) begin
        failures++; $display("FAIL repeat_spacing count=%0d exp first=7 gaps %0d,%0d", t.size(), DLY, PER);
      end
    end else if (t.size() != 1) begin
      failures++; $display("FAIL single_pulse count=%0d exp=1", t.size());
    end
  endtask

  task automatic test_lock();
    int locked_pulses = 0;
    bit [3:0] b;
    for (int i = 0; i < 95; i++) begin
      if (i < 10)      b = 4'b0001;
      else if (i < 40) b = 4'b0101;
      else if (i < 60) b = 4'b0000;
      else if (i < 72) b = 4'b0100;
      else             b = 4'b0000;
      tick(b, 1'b1);
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL lock i=%0d got=%b exp=%b", i, {obs_p, busy}, {exp_p, exp_busy});
      end
      if (i >= 17 && i < 45) begin
        if (obs_p != 4'b0000) locked_pulses++;
        if (busy !== 1'b1) locked_pulses++;
      end
    end
    checks++;
    if (locked_pulses != 0) begin
      failures++; $display("FAIL lock_window events=%0d exp=0", locked_pulses);
    end
  endtask

  task automatic test_set_en_off();
    int cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick((i < 15) ? 4'b0100 : 4'b0000, 1'b0);
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL set_en_off i=%0d got=%b exp=%b", i, {obs_p, busy}, {exp_p, exp_busy});
      end
      if (obs_p != 4'b0000) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++; $display("FAIL set_en_off_count got=%0d exp=0", cnt);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int guard = 0;
    bit hit = 1'b0;
    while (!hit && guard < 100) begin
      tick(4'b0001, 1'b1);
      guard++;
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL mid_pre i=%0d got=%b exp=%b", guard, {obs_p, busy}, {exp_p, exp_busy});
      end
      if (exp_p != 4'b0000 && npulse >= (AUTO ? 2 : 1)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL mid_timeout cycles=%0d exp pulse before 100", guard);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({obs_p, busy} !== 5'b00000) begin
      failures++; $display("FAIL mid_reset_async got=%b exp=00000", {obs_p, busy});
    end
    tick(4'b0001, 1'b1);
    tick(4'b0001, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick((i < 14) ? 4'b0001 : 4'b0000, 1'b1);
      checks++;
      if ({obs_p, busy} !== {exp_p, exp_busy}) begin
        failures++; $display("FAIL mid_post i=%0d got=%b exp=%b", i, {obs_p, busy}, {exp_p, exp_busy});
      end
    end
  endtask

  task automatic test_random();
    bit [3:0] b;
    bit       en;
    int       len;
    int       r;
    for (int s = 0; s < 30; s++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      b = 4'b0001 << $urandom_range(0, 3);
      else if (r <= 7) b = 4'b0000;
      else             b = (4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        tick(b, en);
        checks++;
        if ({obs_p, busy} !== {exp_p, exp_busy}) begin
          failures++; $display("FAIL random seg=%0d i=%0d got=%b exp=%b", s, i, {obs_p, busy}, {exp_p, exp_busy});
        end
        checks++;
        if ($countones(obs_p) > 1) begin
          failures++; $display("FAIL onehot_pulse got=%b exp at most one bit", obs_p);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_lock();
    test_set_en_off();
    test_reset_mid_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
